// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, lane record type and per-byte update helpers.
// The running state is held MSB-first; finalize maps it to the reflected FCS.
package crc_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'h2144DF1C;

  typedef struct packed {
    logic [7:0] data_word;
    logic       data_valid;
  } crc_word_t;

  // Reflected input byte is folded into the MSB-first register
  function automatic logic [31:0] crc32_byte(input logic [31:0] state, input logic [7:0] data);
    logic [31:0] s;
    logic [7:0]  rev;
    for (int i = 0; i < 8; i++) rev[i] = data[7-i];
    s = state ^ {rev, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      s = s[31] ? ((s << 1) ^ CRC_POLY) : (s << 1);
    end
    return s;
  endfunction

  function automatic logic [31:0] crc32_finalize(input logic [31:0] state);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = state[31-i];
    return ~r;
  endfunction

endpackage

// File: rtl/crc32_lane_fold.sv
// Combinational fold of one beat's byte lanes into the running CRC state.
// Masked lanes pass the state through, so the output is the state after the last kept lane.
module crc32_lane_fold
  import crc_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [31:0]            crc_in,
  input  crc_word_t [LANES-1:0]  lane_words,
  output logic [31:0]            crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < LANES; i++) begin
      if (lane_words[i].data_valid) crc_out = crc32_byte(crc_out, lane_words[i].data_word);
    end
  end

endmodule

// File: rtl/crc32_stream_engine.sv
// Streaming Ethernet CRC-32 engine: folds framed beats, emits FCS (GEN) or verdict (CHK)
// through a one-entry result buffer that passes through when popped and refilled together.
module crc32_stream_engine
  import crc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32,
  parameter int CHECK_MODE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_abort,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [CRC_WIDTH-1:0]    o_crc,
  output logic                    o_crc_err,
  output logic                    o_crc_valid,
  input  logic                    i_crc_ready,
  output logic                    o_proto_err
);

  localparam int LANES = DATA_WIDTH / 8;

  if (CRC_WIDTH != 32) begin : g_bad_crc_width
    $error("crc32_stream_engine: CRC_WIDTH must be 32");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("crc32_stream_engine: DATA_WIDTH must be 32 or 64");
  end

  logic [31:0]           crc_q;
  logic [31:0]           crc_fold;
  logic [31:0]           crc_final;
  crc_word_t [LANES-1:0] lane_words;
  logic                  beat_fire;
  logic                  beat_take;
  logic                  result_pop;
  logic                  keep_contig;
  logic                  keep_full;
  logic                  keep_none;
  logic                  keep_bad;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_words[i].data_word  = s_tdata[8*i +: 8];
      lane_words[i].data_valid = s_tkeep[i];
    end
  end

  crc32_lane_fold #(.LANES(LANES)) u_lane_fold (
    .crc_in     (crc_q),
    .lane_words (lane_words),
    .crc_out    (crc_fold)
  );

  assign crc_final  = crc32_finalize(crc_fold);
  assign s_tready   = ~o_crc_valid | i_crc_ready;
  assign beat_fire  = s_tvalid & s_tready;
  // An aborted beat is dropped entirely, including its keep checks
  assign beat_take  = beat_fire & ~i_abort;
  assign result_pop = o_crc_valid & i_crc_ready;

  // Legal keep is a prefix of lanes; a partial prefix is only allowed on the last beat
  assign keep_contig = ((s_tkeep & (s_tkeep + LANES'(1))) == '0);
  assign keep_full   = &s_tkeep;
  assign keep_none   = ~|s_tkeep;
  assign keep_bad    = ~keep_contig | (~s_tlast & ~keep_full & ~keep_none);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_q       <= CRC_INIT;
      o_crc       <= '0;
      o_crc_err   <= 1'b0;
      o_crc_valid <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      o_proto_err <= beat_take & keep_bad;

      if (i_abort) begin
        crc_q <= CRC_INIT;
      end else if (beat_fire) begin
        crc_q <= s_tlast ? CRC_INIT : crc_fold;
      end

      if (beat_take & s_tlast) begin
        o_crc_valid <= 1'b1;
        o_crc       <= crc_final;
        o_crc_err   <= (CHECK_MODE != 0) && (crc_final != CRC_RESIDUE);
      end else if (result_pop) begin
        o_crc_valid <= 1'b0;
      end
    end
  end

endmodule
